// File: rtl/dac8_sample_streamer.sv
// Paced sample FIFO feeding the EF_DAC8 VALUE bus: buffers producer samples and
// releases one per programmable period. Optional output slew limit: DAC8_STREAM_SLEW_EN.
module dac8_sample_streamer #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                            UserCLK,
    input  logic                            RST,
    input  logic                            enable,
    input  logic [DIV_WIDTH-1:0]            divider,
    input  logic [7:0]                      s_data,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic                            clr_underflow,
`ifdef DAC8_STREAM_SLEW_EN
    input  logic [7:0]                      slew_step,
`endif
    output logic [7:0]                      VALUE,
    output logic                            strobe,
    output logic [$clog2(FIFO_DEPTH):0]     level,
    output logic                            underflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);

    logic [7:0]           fifo_mem [FIFO_DEPTH];
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic [7:0]           value_q, value_d;
    logic                 strobe_q, strobe_d;
    logic                 underflow_q, underflow_d;
    logic                 push, pop, tick, uf_set;
    logic [7:0]           head;

`ifdef DAC8_STREAM_SLEW_EN
    logic [7:0] target_q, target_d;

    // Step cur toward tgt by at most step (0 = unlimited); never crosses tgt.
    function automatic logic [7:0] slew_to(input logic [7:0] cur, input logic [7:0] tgt,
                                           input logic [7:0] step);
        logic [7:0] diff;
        logic [7:0] d;
        diff = (tgt >= cur) ? tgt - cur : cur - tgt;
        d    = (step == 8'd0 || diff < step) ? diff : step;
        return (tgt >= cur) ? cur + d : cur - d;
    endfunction
`endif

    assign s_ready   = (level_q != FULL);
    assign VALUE     = value_q;
    assign strobe    = strobe_q;
    assign level     = level_q;
    assign underflow = underflow_q;

    always_comb begin
        push        = s_valid && s_ready;
        tick        = enable && (cnt_q >= divider);
        pop         = tick && (level_q != '0);
        head        = fifo_mem[rd_ptr_q];
        uf_set      = 1'b0;
        cnt_d       = '0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        value_d     = value_q;
        strobe_d    = 1'b0;
`ifdef DAC8_STREAM_SLEW_EN
        target_d    = target_q;
`endif

        if (enable) cnt_d = tick ? '0 : cnt_q + 1'b1;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      level_d = level_q + 1'b1;
        else if (pop && !push) level_d = level_q - 1'b1;

`ifdef DAC8_STREAM_SLEW_EN
        // An empty tick keeps walking toward an unreached target before it counts as underflow.
        if (pop) begin
            target_d = head;
            value_d  = slew_to(value_q, head, slew_step);
            strobe_d = 1'b1;
        end else if (tick) begin
            if (value_q != target_q) begin
                value_d  = slew_to(value_q, target_q, slew_step);
                strobe_d = 1'b1;
            end else begin
                uf_set = 1'b1;
            end
        end
`else
        if (pop) begin
            value_d  = head;
            strobe_d = 1'b1;
        end else if (tick) begin
            uf_set = 1'b1;
        end
`endif

        underflow_d = uf_set ? 1'b1 : (clr_underflow ? 1'b0 : underflow_q);
    end

    always_ff @(posedge UserCLK) begin
        if (RST) begin
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            value_q     <= 8'h80;
            strobe_q    <= 1'b0;
            underflow_q <= 1'b0;
`ifdef DAC8_STREAM_SLEW_EN
            target_q    <= 8'h80;
`endif
        end else begin
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            value_q     <= value_d;
            strobe_q    <= strobe_d;
            underflow_q <= underflow_d;
`ifdef DAC8_STREAM_SLEW_EN
            target_q    <= target_d;
`endif
        end
    end

    // Storage needs no reset: occupancy is tracked by level and the pointers.
    always_ff @(posedge UserCLK) begin
        if (!RST && push) fifo_mem[wr_ptr_q] <= s_data;
    end

endmodule

// File: tb/tb_dac8_sample_streamer.sv
// Bench for dac8_sample_streamer: vector table, directed corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_dac8_sample_streamer;
    localparam int DEPTH = 8;
    localparam int DW    = 16;
    localparam int LW    = 4;

    logic          UserCLK = 1'b0;
    logic          RST = 1'b1;
    logic          enable = 1'b0;
    logic [DW-1:0] divider = '0;
    logic [7:0]    s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          clr_underflow = 1'b0;
    logic [7:0]    slew_step = 8'd0;
    logic [7:0]    VALUE;
    logic          strobe;
    logic [LW-1:0] level;
    logic          underflow;

    always #5 UserCLK = ~UserCLK;

    dac8_sample_streamer #(.FIFO_DEPTH(DEPTH), .DIV_WIDTH(DW)) dut (
        .UserCLK(UserCLK), .RST(RST), .enable(enable), .divider(divider),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .clr_underflow(clr_underflow),
`ifdef DAC8_STREAM_SLEW_EN
        .slew_step(slew_step),
`endif
        .VALUE(VALUE), .strobe(strobe), .level(level), .underflow(underflow)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state: the FIFO as a queue, the period counter as a plain int.
    logic [7:0] mq[$];
    int         m_cnt = 0;
    int         m_val = 8'h80;
    int         m_tgt = 8'h80;
    bit         m_strb = 1'b0;
    bit         m_uf = 1'b0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int toward(input int cur, input int tgt, input int step);
        int d;
        d = (tgt > cur) ? tgt - cur : cur - tgt;
        if (step != 0 && d > step) d = step;
        return (tgt > cur) ? cur + d : cur - d;
    endfunction

    task automatic model_edge();
        bit acc, tk;
        if (RST) begin
            mq.delete();
            m_cnt = 0; m_val = 8'h80; m_tgt = 8'h80; m_strb = 0; m_uf = 0;
            return;
        end
        acc = s_valid && (mq.size() != DEPTH);
        tk  = enable && (m_cnt >= int'(divider));
        m_cnt  = !enable ? 0 : (tk ? 0 : m_cnt + 1);
        m_strb = 0;
        if (tk) begin
            if (mq.size() > 0) begin
                m_tgt  = int'(mq.pop_front());
                m_val  = toward(m_val, m_tgt, int'(slew_step));
                m_strb = 1;
            end else if (m_val != m_tgt) begin
                m_val  = toward(m_val, m_tgt, int'(slew_step));
                m_strb = 1;
            end else begin
                m_uf = 1;
            end
        end
        if (!(tk && !(m_strb) ) || !tk) begin end
        if (!(tk && m_uf && !m_strb && (m_val == m_tgt)) && clr_underflow && !(tk && !m_strb))
            m_uf = 0;
        if (acc) mq.push_back(s_data);
    endtask

    task automatic step();
        @(posedge UserCLK);
        model_edge();
        #1;
        chk("model_value", int'(VALUE), m_val);
        chk("model_strobe", int'(strobe), int'(m_strb));
        chk("model_level", int'(level), mq.size());
        chk("model_ready", int'(s_ready), int'(mq.size() != DEPTH));
        chk("model_underflow", int'(underflow), int'(m_uf));
    endtask

    typedef struct {
        logic          rst;
        logic          en;
        logic [DW-1:0] div;
        logic [7:0]    data;
        logic          valid;
        logic [7:0]    e_val;
        logic          e_strb;
        logic [LW-1:0] e_lvl;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(input logic rst, input logic en, input logic [DW-1:0] div,
                                input logic [7:0] data, input logic valid,
                                input logic [7:0] ev, input logic es, input logic [LW-1:0] el);
        vec_t v;
        v.rst = rst; v.en = en; v.div = div; v.data = data; v.valid = valid;
        v.e_val = ev; v.e_strb = es; v.e_lvl = el;
        return v;
    endfunction

    initial begin
        int seen;
        int n;
        // Reset, then three back-to-back pushes released every 4 cycles (divider=3).
        tbl[0]  = mk(1'b1, 1'b0, 16'd0, 8'h00, 1'b0, 8'h80, 1'b0, 4'd0);
        tbl[1]  = mk(1'b1, 1'b0, 16'd0, 8'h00, 1'b0, 8'h80, 1'b0, 4'd0);
        tbl[2]  = mk(1'b0, 1'b1, 16'd3, 8'h10, 1'b1, 8'h80, 1'b0, 4'd1);
        tbl[3]  = mk(1'b0, 1'b1, 16'd3, 8'h20, 1'b1, 8'h80, 1'b0, 4'd2);
        tbl[4]  = mk(1'b0, 1'b1, 16'd3, 8'h30, 1'b1, 8'h80, 1'b0, 4'd3);
        tbl[5]  = mk(1'b0, 1'b1, 16'd3, 8'h00, 1'b0, 8'h10, 1'b1, 4'd2);
        tbl[6]  = mk(1'b0, 1'b1, 16'd3, 8'h00, 1'b0, 8'h10, 1'b0, 4'd2);
        tbl[7]  = mk(1'b0, 1'b1, 16'd3, 8'h00, 1'b0, 8'h10, 1'b0, 4'd2);
        tbl[8]  = mk(1'b0, 1'b1, 16'd3, 8'h00, 1'b0, 8'h10, 1'b0, 4'd2);
        tbl[9]  = mk(1'b0, 1'b1, 16'd3, 8'h00, 1'b0, 8'h20, 1'b1, 4'd1);
        tbl[10] = mk(1'b0, 1'b1, 16'd3, 8'h00, 1'b0, 8'h20, 1'b0, 4'd1);
        tbl[11] = mk(1'b0, 1'b1, 16'd3, 8'h00, 1'b0, 8'h20, 1'b0, 4'd1);
        tbl[12] = mk(1'b0, 1'b1, 16'd3, 8'h00, 1'b0, 8'h20, 1'b0, 4'd1);
        tbl[13] = mk(1'b0, 1'b1, 16'd3, 8'h00, 1'b0, 8'h30, 1'b1, 4'd0);

        for (int i = 0; i < 14; i++) begin
            RST = tbl[i].rst; enable = tbl[i].en; divider = tbl[i].div;
            s_data = tbl[i].data; s_valid = tbl[i].valid;
            step();
            chk($sformatf("tbl%0d_value", i), int'(VALUE), int'(tbl[i].e_val));
            chk($sformatf("tbl%0d_strobe", i), int'(strobe), int'(tbl[i].e_strb));
            chk($sformatf("tbl%0d_level", i), int'(level), int'(tbl[i].e_lvl));
            chk($sformatf("tbl%0d_ready", i), int'(s_ready), 1);
            chk($sformatf("tbl%0d_underflow", i), int'(underflow), 0);
        end
        s_valid = 1'b0; enable = 1'b0;

        // Fill past full while paused, then drain one sample per cycle.
        RST = 1'b1; step(); RST = 1'b0;
        for (int i = 0; i < 9; i++) begin
            s_valid = 1'b1; s_data = 8'h41 + 8'(i);
            step();
            if (i >= 7) begin
                chk("full_level", int'(level), 8);
                chk("full_ready", int'(s_ready), 0);
            end
        end
        s_valid = 1'b0; enable = 1'b1; divider = 16'd0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("drain_strobe", int'(strobe), 1);
            chk("drain_value", int'(VALUE), 8'h41 + i);
        end
        step();
        chk("drain_end_strobe", int'(strobe), 0);
        chk("drain_end_underflow", int'(underflow), 1);

        // Starvation: last value held, sticky flag, set beats clear on a tick.
        enable = 1'b0; RST = 1'b1; step(); RST = 1'b0;
        enable = 1'b1; divider = 16'd1; s_valid = 1'b1; s_data = 8'hAB;
        step();
        s_valid = 1'b0;
        repeat (6) step();
        chk("starve_value", int'(VALUE), 8'hAB);
        chk("starve_underflow", int'(underflow), 1);
        n = 0;
        while (m_cnt < int'(divider) && n < 4) begin step(); n++; end
        chk("tick_phase_found", int'(m_cnt >= int'(divider)), 1);
        clr_underflow = 1'b1; step(); clr_underflow = 1'b0;
        chk("clr_on_tick_underflow", int'(underflow), 1);
        clr_underflow = 1'b1; step(); clr_underflow = 1'b0;
        chk("clr_off_tick_underflow", int'(underflow), 0);

        // Reset arriving on a tick cycle with five samples queued.
        enable = 1'b0; RST = 1'b1; step(); RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; s_data = 8'hC1 + 8'(i); step();
        end
        s_valid = 1'b0;
        chk("pre_reset_level", int'(level), 5);
        enable = 1'b1; divider = 16'd2;
        step(); step();
        RST = 1'b1; step(); RST = 1'b0;
        chk("midreset_value", int'(VALUE), 8'h80);
        chk("midreset_level", int'(level), 0);
        chk("midreset_strobe", int'(strobe), 0);
        divider = 16'd0; seen = 0;
        repeat (12) begin step(); if (strobe) seen++; end
        chk("midreset_no_stale", seen, 0);

`ifdef DAC8_STREAM_SLEW_EN
        // Slew-limited approach from midscale to F0 in 0x20 steps.
        enable = 1'b0; RST = 1'b1; step(); RST = 1'b0;
        slew_step = 8'h20; s_valid = 1'b1; s_data = 8'hF0; step(); s_valid = 1'b0;
        enable = 1'b1; divider = 16'd0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("slew_value", int'(VALUE), (i == 3) ? 8'hF0 : 8'hA0 + 8'h20 * i);
            chk("slew_underflow", int'(underflow), 0);
        end
        step();
        chk("slew_done_underflow", int'(underflow), 1);
        chk("slew_done_value", int'(VALUE), 8'hF0);
`endif

        // Randomized traffic against the model.
        RST = 1'b1; step(); RST = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            RST = ($urandom_range(0, 249) == 0);
            enable = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) divider = 16'($urandom_range(0, 6));
            s_valid = 1'($urandom_range(0, 1));
            s_data = 8'($urandom);
            clr_underflow = ($urandom_range(0, 7) == 0);
`ifdef DAC8_STREAM_SLEW_EN
            if ($urandom_range(0, 31) == 0) slew_step = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
`endif
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dac8_sample_streamer.md
Name: dac8_sample_streamer

Overview:
Fabric-side sample pacing stage that sits directly upstream of the EF_DAC8 BEL tile and drives its 8-bit VALUE bus.
- Accepts 8-bit samples from user logic over a valid/ready handshake and buffers them in a small FIFO.
- Releases one sample per programmable sample period, so the DAC sees a jitter-free, evenly spaced waveform that is independent of producer burstiness.
- Holds the last output and flags underflow when the producer starves.

Parameters:
FIFO_DEPTH, 8, number of sample entries; power of two, 2..64.
DIV_WIDTH, 16, width of the sample-period divider.

Ports:
UserCLK  input  1  fabric user clock; all logic rising-edge.
RST  input  1  synchronous active-high reset.
enable  input  1  1 = pacing counter runs and samples are released; 0 = paused.
divider  input  DIV_WIDTH  sample period minus one, in UserCLK cycles.
s_data  input  8  sample from producer.
s_valid  input  1  s_data valid.
s_ready  output  1  FIFO can accept a sample.
clr_underflow  input  1  clears the sticky underflow flag.
VALUE  output  8  registered sample to the EF_DAC8 VALUE inputs.
strobe  output  1  one-cycle pulse when VALUE is updated.
level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
underflow  output  1  sticky flag: a sample tick found the FIFO empty.

Behaviour:
- Reset (RST=1 at a clock edge), values after the edge:
  - VALUE=8'h80 (midscale), strobe=0, underflow=0, level=0, s_ready=1.
  - Pacing counter=0, read/write pointers=0.
  - Reset mid-operation discards all FIFO contents and any pending tick.
- Handshake:
  - s_ready = (level != FIFO_DEPTH); it is combinational from registered level only, never from s_valid or the pop.
  - Push occurs when s_valid && s_ready. s_data is written at that edge and level increments.
  - When full, s_ready=0 even if a pop happens in the same cycle; no pop-aware ready.
- Pacing counter cnt (DIV_WIDTH bits):
  - enable=0: cnt forced to 0, no tick, no pops, VALUE and strobe (0) held. The FIFO still accepts pushes.
  - enable=1: tick = (cnt >= divider). On tick, cnt<=0; otherwise cnt<=cnt+1.
  - divider=0 gives a tick every cycle.
  - If divider is lowered below the current cnt, the next cycle ticks. No wrap past the all-ones value can occur, because of the >= compare.
- Tick with level>0:
  - The head entry is popped; VALUE<=head at the tick edge, and strobe=1 for exactly that following cycle.
  - Latency from push to VALUE is at least one cycle: a sample pushed in cycle N is eligible for the first tick in cycle N+1 or later.
- Tick with level==0:
  - VALUE holds its previous value, strobe stays 0, underflow<=1.
  - A push in the same cycle is not bypassed; it lands in the FIFO for the next tick.
- Simultaneous push and pop: level unchanged, and both pointers advance modulo FIFO_DEPTH.
- underflow: set has priority over clr_underflow in the same cycle; otherwise clr_underflow=1 clears it.
- Pointers wrap naturally at FIFO_DEPTH. Full/empty are derived from level.

Optional Feature:
Macro DAC8_STREAM_SLEW_EN.
- Defined:
  - Adds input slew_step[7:0].
  - On each tick that pops a sample, VALUE moves toward the popped sample by at most slew_step: VALUE<=VALUE±min(|target−VALUE|, slew_step), using unsigned arithmetic with no overflow past 0/255.
  - The unreached target is retained as the current target. Ticks with an empty FIFO continue stepping toward that target without setting underflow, provided VALUE != target; once VALUE == target, an empty tick sets underflow as in the base behaviour.
  - slew_step=0 means unlimited, i.e. identical to the base behaviour.
- Undefined: port absent, base behaviour exactly.

Test Plan:
1. Reset values: assert RST for 2 cycles then release → VALUE=8'h80, strobe=0, level=0, s_ready=1, underflow=0.
2. Pacing and order: divider=3, enable=1, push 8'h10,8'h20,8'h30 back-to-back → VALUE takes 10,20,30 on strobes spaced exactly 4 cycles apart; level returns to 0.
3. Full FIFO: enable=0, push 9 samples with FIFO_DEPTH=8 → s_ready=0 after the 8th, the 9th is not accepted, level=8. Then enable=1, divider=0 → 8 consecutive strobes with values in push order.
4. Underflow: divider=1, single push 8'hAB, wait 6 cycles → VALUE stays 8'hAB and underflow=1. Pulse clr_underflow on a tick cycle with the FIFO empty → underflow remains 1; pulse it on a non-tick cycle → underflow=0.
5. Reset mid-stream: level=5, divider=2, assert RST during a tick cycle → next cycle VALUE=8'h80, level=0, no strobe, and the old samples never appear.
6. Slew (DAC8_STREAM_SLEW_EN defined): slew_step=8'h20, VALUE=8'h80, push 8'hF0, divider=0 → VALUE sequence A0,C0,E0,F0 on successive ticks, with no underflow set until the tick after F0.
